systolic_input_setup: RTL

Parametrised input-staging unit between the unified buffer and the left edge of an N-row systolic array. On a start command it reads an N×K activation matrix from the unified buffer into a local staging store. It then streams the matrix into the array with the per-row diagonal skew and zero padding applied automatically, so the array receives its skewed input without any host-side sequencing. It supports run-time length K, stalls via hold, and signals completion.

---
 rtl/systolic_input_setup_if.sv | 33 +++
 rtl/systolic_input_setup.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/systolic_input_setup_if.sv
// Host/memory-side bundle for systolic_input_setup: command, unified-buffer read
// port and the skewed activation stream toward the array's left edge.
interface systolic_input_setup_if #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 6,
  parameter int MAX_K  = 8
) ();
  localparam int KW = $clog2(MAX_K + 1);

  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [KW-1:0]       k_len;
  logic                hold;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [MEM_W-1:0]    mem_rd_data;
  logic [N*DATA_W-1:0] a_out;
  logic                a_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, base_addr, k_len, hold, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, a_out, a_valid, busy, done
  );

  modport slave (
    input  start, base_addr, k_len, hold, mem_rd_data,
    output mem_rd_en, mem_rd_addr, a_out, a_valid, busy, done
  );
endinterface

// File: rtl/systolic_input_setup.sv
// Loads an N x K activation tile from the unified buffer into a staging store,
// then streams it into the systolic array with per-row diagonal skew.
module systolic_input_setup #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 6,
  parameter int MAX_K  = 8
) (
  input logic clk,
  input logic reset,
  systolic_input_setup_if.slave bus
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int IW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(MAX_K + N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     row_q, row_d;
  logic [KW-1:0]     col_q, col_d;
  logic [TW-1:0]     t_q, t_d;
  logic              wr_en_q, wr_en_d;
  logic [RW-1:0]     wr_row_q, wr_row_d;
  logic [IW-1:0]     wr_col_q, wr_col_d;
  logic              done_q, done_d;
  logic [KW-1:0]     k_sel;
  logic [TW-1:0]     t_last;
  logic [DATA_W-1:0] stage_q [N][MAX_K];
  logic [N*DATA_W-1:0] a_out_c;
  logic              unused_hi;

  assign unused_hi = ^bus.mem_rd_data[MEM_W-1:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      t_q      <= '0;
      wr_en_q  <= 1'b0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      t_q      <= t_d;
      wr_en_q  <= wr_en_d;
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      done_q   <= done_d;
    end
  end

  // Staging contents are don't-care after reset; stale entries are masked on output.
  always_ff @(posedge clk) begin
    if (wr_en_q) stage_q[wr_row_q][wr_col_q] <= bus.mem_rd_data[DATA_W-1:0];
  end

  always_comb begin
    k_sel  = (bus.k_len > KW'(MAX_K)) ? KW'(MAX_K) : bus.k_len;
    t_last = TW'(k_q) + TW'(N) - TW'(2);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    addr_d   = addr_q;
    row_d    = row_q;
    col_d    = col_q;
    t_d      = t_q;
    wr_en_d  = 1'b0;
    wr_row_d = row_q;
    wr_col_d = col_q[IW-1:0];
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (k_sel == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            k_d     = k_sel;
            addr_d  = bus.base_addr;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      S_LOAD: begin
        wr_en_d = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        if (col_q == k_q - KW'(1)) begin
          col_d = '0;
          if (row_q == RW'(N - 1)) state_d = S_WAIT;
          else                     row_d   = row_q + RW'(1);
        end else begin
          col_d = col_q + KW'(1);
        end
      end
      S_WAIT: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (!bus.hold) begin
          if (t_q == t_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row i lags row 0 by i beats; anything outside its K-wide window is zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic signed [31:0] j;
    logic [DATA_W-1:0]  ch;
    always_comb begin
      j  = $signed({{(32-TW){1'b0}}, t_q}) - gi;
      ch = '0;
      if (state_q == S_STREAM && j >= 0 && j < $signed({{(32-KW){1'b0}}, k_q}))
        ch = stage_q[gi][j[IW-1:0]];
    end
    assign a_out_c[gi*DATA_W +: DATA_W] = ch;
  end

  assign bus.mem_rd_en   = (state_q == S_LOAD);
  assign bus.mem_rd_addr = addr_q;
  assign bus.a_out       = a_out_c;
  assign bus.a_valid     = (state_q == S_STREAM) && !bus.hold;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
endmodule
